// File: rtl/mmio_bridge.sv
// Data-memory bridge: forwards CPU loads/stores to RAM and decodes an MMIO window
// at/above MMIO_BASE (debounced buttons, press flags, accel snapshot, tick, output regs).
module mmio_bridge #(
  parameter int unsigned            ADDR_WIDTH      = 12,
  parameter int unsigned            DATA_WIDTH      = 32,
  parameter logic [ADDR_WIDTH-1:0]  MMIO_BASE       = 12'hF00,
  parameter int unsigned            NUM_IN          = 4,
  parameter int unsigned            DEBOUNCE_CYCLES = 500000,
  parameter int unsigned            NUM_OUT         = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  input  logic                          cpu_wren,
  input  logic [DATA_WIDTH-1:0]         cpu_wdata,
  output logic [DATA_WIDTH-1:0]         cpu_rdata,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic                          ram_wren,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic [DATA_WIDTH-1:0]         ram_rdata,
  input  logic [NUM_IN-1:0]             btn_raw,
  input  logic [8:0]                    accel_x,
  input  logic [8:0]                    accel_y,
  output logic [NUM_IN-1:0]             btn_level,
  output logic [NUM_OUT*DATA_WIDTH-1:0] out_regs
);

  localparam int unsigned           CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_LEVEL = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OFF_PRESS = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OFF_ACCEL = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OFF_TICK  = ADDR_WIDTH'(3);
  localparam int unsigned           OFF_OUT0  = 4;

  logic                  is_mmio;
  logic [ADDR_WIDTH-1:0] off;
  logic                  mmio_wr;
  logic                  mmio_rd;

  logic                  sel_q;
  logic [DATA_WIDTH-1:0] mmio_q;
  logic [DATA_WIDTH-1:0] mmio_rdata;

  logic [NUM_IN-1:0]     sync1;
  logic [NUM_IN-1:0]     sync2;
  logic [NUM_IN-1:0]     level;
  logic [CNT_W-1:0]      cnt [NUM_IN];
  logic [NUM_IN-1:0]     rise;
  logic [NUM_IN-1:0]     press;
  logic [NUM_IN-1:0]     press_clr;

  logic [17:0]           snap;
  logic [31:0]           tick;
  logic [DATA_WIDTH-1:0] out_q [NUM_OUT];

  assign is_mmio   = (cpu_addr >= MMIO_BASE);
  assign off       = cpu_addr - MMIO_BASE;
  assign mmio_wr   = cpu_wren & is_mmio;
  assign mmio_rd   = ~cpu_wren & is_mmio;

  assign ram_addr  = cpu_addr;
  assign ram_wdata = cpu_wdata;
  assign ram_wren  = cpu_wren & ~is_mmio;

  assign btn_level = level;
  assign cpu_rdata = reset ? '0 : (sel_q ? mmio_q : ram_rdata);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      for (int unsigned i = 0; i < NUM_IN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]   <= '0;
          level[i] <= ~level[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Rising edge is known one cycle early: it is the cycle the counter expires on a 1.
  always_comb begin
    rise = '0;
    for (int unsigned i = 0; i < NUM_IN; i++)
      rise[i] = sync2[i] & ~level[i] & (cnt[i] == CNT_LAST);
  end

  always_comb begin
    press_clr = '0;
    if (mmio_wr && off == OFF_PRESS)      press_clr = cpu_wdata[NUM_IN-1:0];
    else if (mmio_rd && off == OFF_PRESS) press_clr = '1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      press <= '0;
      snap  <= '0;
      tick  <= '0;
      for (int unsigned k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      press <= (press & ~press_clr) | rise;
      // Snapshot holds only while it is being read so the read sees last cycle's sample.
      if (!(mmio_rd && off == OFF_ACCEL)) snap <= {accel_y, accel_x};
      if (mmio_wr && off == OFF_TICK) tick <= 32'(cpu_wdata);
      else                            tick <= tick + 32'd1;
      for (int unsigned k = 0; k < NUM_OUT; k++)
        if (mmio_wr && off == ADDR_WIDTH'(OFF_OUT0 + k)) out_q[k] <= cpu_wdata;
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (off)
      OFF_LEVEL: mmio_rdata = DATA_WIDTH'(level);
      OFF_PRESS: mmio_rdata = DATA_WIDTH'(press);
      OFF_ACCEL: mmio_rdata = DATA_WIDTH'(snap);
      OFF_TICK:  mmio_rdata = DATA_WIDTH'(tick);
      default: begin
        for (int unsigned k = 0; k < NUM_OUT; k++)
          if (off == ADDR_WIDTH'(OFF_OUT0 + k)) mmio_rdata = out_q[k];
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_q  <= 1'b0;
      mmio_q <= '0;
    end else begin
      sel_q  <= is_mmio;
      mmio_q <= is_mmio ? mmio_rdata : '0;
    end
  end

  always_comb begin
    out_regs = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++)
      out_regs[k*DATA_WIDTH +: DATA_WIDTH] = out_q[k];
  end

endmodule

// File: tb/tb_mmio_bridge.sv
// Testbench for mmio_bridge: directed scenarios followed by random traffic, all
// checked against a cycle-level behavioural model of the memory map.
module tb_mmio_bridge;

  localparam int          DEB  = 8;
  localparam logic [11:0] BASE = 12'hF00;

  logic         clock = 1'b0;
  logic         reset;
  logic [11:0]  cpu_addr;
  logic         cpu_wren;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic [11:0]  ram_addr;
  logic         ram_wren;
  logic [31:0]  ram_wdata;
  logic [31:0]  ram_rdata;
  logic [3:0]   btn_raw;
  logic [8:0]   accel_x;
  logic [8:0]   accel_y;
  logic [3:0]   btn_level;
  logic [127:0] out_regs;

  always #5 clock = ~clock;

  mmio_bridge #(
    .ADDR_WIDTH(12), .DATA_WIDTH(32), .MMIO_BASE(12'hF00),
    .NUM_IN(4), .DEBOUNCE_CYCLES(DEB), .NUM_OUT(4)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_wren(cpu_wren), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .btn_raw(btn_raw), .accel_x(accel_x), .accel_y(accel_y),
    .btn_level(btn_level), .out_regs(out_regs)
  );

  function automatic logic [31:0] init_word(input int a);
    return 32'hC0DE_0000 ^ (32'(a) * 32'h0000_9E37);
  endfunction

  // Synchronous RAM behind the bridge; unwritten words return a fixed pattern.
  bit [31:0] ram [4096];
  bit        ram_written [4096];
  always @(posedge clock) begin
    if (ram_wren) begin
      ram[ram_addr]         <= ram_wdata;
      ram_written[ram_addr] <= 1'b1;
    end
    ram_rdata <= ram_written[ram_addr] ? ram[ram_addr] : init_word(int'(ram_addr));
  end

  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] mem_model [4096];
  logic [3:0]  m_level, m_s1, m_s2, m_flags;
  int          m_run [4];
  logic [8:0]  m_sx, m_sy;
  logic [31:0] m_tick;
  logic [31:0] m_out [4];

  function automatic logic [31:0] mmio_value(input int o);
    case (o)
      0: return {28'b0, m_level};
      1: return {28'b0, m_flags};
      2: return {14'b0, m_sy, m_sx};
      3: return m_tick;
      4, 5, 6, 7: return m_out[o-4];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic [11:0] a, input logic we,
                            input logic [31:0] wd, input logic [3:0] b,
                            input logic [8:0] ax, input logic [8:0] ay,
                            output logic [31:0] exp_rd);
    logic       mm;
    int         o;
    logic [3:0] rise, clr;
    mm = (a >= BASE);
    o  = mm ? int'(a) - int'(BASE) : -1;
    exp_rd = mm ? mmio_value(o) : mem_model[a];
    if (we && !mm) mem_model[a] = wd;
    if (rst) begin
      m_level = 0; m_s1 = 0; m_s2 = 0; m_flags = 0;
      m_sx = 0; m_sy = 0; m_tick = 0;
      for (int i = 0; i < 4; i++) begin m_run[i] = 0; m_out[i] = 0; end
      return;
    end
    rise = 0;
    // A level is accepted after DEB consecutive cycles of disagreement.
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          if (m_level[i]) rise[i] = 1'b1;
        end
      end else m_run[i] = 0;
    end
    clr = 0;
    if (mm && o == 1) clr = we ? wd[3:0] : 4'hF;
    m_flags = (m_flags & ~clr) | rise;
    if (!(mm && o == 2 && !we)) begin m_sx = ax; m_sy = ay; end
    if (mm && o == 3 && we) m_tick = wd;
    else                    m_tick = m_tick + 32'd1;
    if (mm && we && o >= 4 && o <= 7) m_out[o-4] = wd;
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  logic [3:0] b;
  logic [8:0] ax, ay;

  task automatic cycle(input logic rst, input logic [11:0] a, input logic we, input logic [31:0] wd);
    logic [31:0] exp_rd;
    reset = rst; cpu_addr = a; cpu_wren = we; cpu_wdata = wd;
    btn_raw = b; accel_x = ax; accel_y = ay;
    #1;
    check("ram_wren", ram_wren, we & (a < BASE));
    check("ram_addr", ram_addr, a);
    check("ram_wdata", ram_wdata, wd);
    model_edge(rst, a, we, wd, b, ax, ay, exp_rd);
    @(posedge clock);
    #1;
    check("btn_level", btn_level, m_level);
    check("out_regs", out_regs, {m_out[3], m_out[2], m_out[1], m_out[0]});
    if (rst)      check("rdata_in_reset", cpu_rdata, 32'h0);
    else if (!we) check("rdata", cpu_rdata, exp_rd);
  endtask

  task automatic idle();                                   cycle(1'b0, 12'h020, 1'b0, 32'h0); endtask
  task automatic rd(input logic [11:0] a);                 cycle(1'b0, a, 1'b0, 32'h0);       endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d); cycle(1'b0, a, 1'b1, d);     endtask

  initial begin
    logic [11:0] a;
    logic        we;
    for (int i = 0; i < 4096; i++) mem_model[i] = init_word(i);
    b = 0; ax = 0; ay = 0;

    repeat (3) cycle(1'b1, 12'h000, 1'b0, 32'h0);
    rd(BASE + 12'd3);
    check("tick_first_after_reset", cpu_rdata, 32'h0);
    rd(BASE + 12'd4);
    check("out0_reset", cpu_rdata, 32'h0);

    wr(12'h010, 32'h1234_5678);
    rd(12'h010);
    check("ram_passthrough", cpu_rdata, 32'h1234_5678);

    wr(BASE + 12'd4, 32'hDEAD_BEEF);
    check("out0_written", out_regs[31:0], 32'hDEAD_BEEF);
    rd(BASE + 12'd4);
    check("out0_readback", cpu_rdata, 32'hDEAD_BEEF);
    rd(BASE + 12'hF0);
    check("unmapped_read", cpu_rdata, 32'h0);

    b[1] = 1'b1;
    repeat (5) idle();
    b[1] = 1'b0;
    repeat (12) idle();
    check("glitch_ignored", btn_level[1], 1'b0);

    b[1] = 1'b1;
    repeat (9) idle();
    check("level_before_full_count", btn_level[1], 1'b0);
    idle();
    check("level_after_full_count", btn_level[1], 1'b1);
    rd(BASE + 12'd1);
    check("press_flag_set", cpu_rdata, 32'h2);
    rd(BASE + 12'd1);
    check("press_flag_cleared_by_read", cpu_rdata, 32'h0);

    b[1] = 1'b0;
    repeat (12) idle();
    b[1] = 1'b1;
    repeat (9) idle();
    rd(BASE + 12'd1);
    check("collision_read_old", cpu_rdata, 32'h0);
    check("collision_level", btn_level[1], 1'b1);
    rd(BASE + 12'd1);
    check("collision_set_wins", cpu_rdata, 32'h2);

    b[1] = 1'b0;
    repeat (12) idle();
    b[1] = 1'b1;
    repeat (10) idle();
    wr(BASE + 12'd1, 32'h2);
    rd(BASE + 12'd1);
    check("w1c_cleared", cpu_rdata, 32'h0);

    wr(BASE + 12'd3, 32'hFFFF_FFFE);
    idle();
    rd(BASE + 12'd3);
    check("tick_max", cpu_rdata, 32'hFFFF_FFFF);
    rd(BASE + 12'd3);
    check("tick_wrap", cpu_rdata, 32'h0);

    ax = 9'h1AB; ay = 9'h055;
    idle();
    ax = 9'h000; ay = 9'h1FF;
    rd(BASE + 12'd2);
    check("accel_snapshot", cpu_rdata, {14'b0, 9'h055, 9'h1AB});

    wr(BASE + 12'd6, 32'h0BAD_F00D);
    b[2] = 1'b1;
    repeat (4) idle();
    cycle(1'b1, 12'h000, 1'b0, 32'h0);
    check("out_regs_after_reset", out_regs, 128'h0);
    rd(BASE + 12'd4);
    check("out0_after_reset", cpu_rdata, 32'h0);
    rd(BASE + 12'd0);
    check("level_reg_after_reset", cpu_rdata, 32'h0);
    repeat (7) idle();
    check("level2_needs_full_count", btn_level[2], 1'b0);
    idle();
    check("level2_after_full_count", btn_level[2], 1'b1);

    for (int n = 0; n < 700; n++) begin
      if ($urandom_range(0, 11) == 0) b[$urandom_range(0, 3)] ^= 1'b1;
      ax = 9'($urandom);
      ay = 9'($urandom);
      if ($urandom_range(0, 1) == 0) a = 12'($urandom_range(0, 12'hEFF));
      else if ($urandom_range(0, 10) == 0) a = BASE + 12'hF0;
      else a = BASE + 12'($urandom_range(0, 9));
      we = ($urandom_range(0, 2) == 0);
      cycle(($urandom_range(0, 249) == 0), a, we, $urandom);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
